// File: rtl/hazard_detect_unit.sv
// -----------------------------------------------------------------------------
// hazard_detect_unit
//
// Hazard detection and stall sequencer for the 5-stage MIPS pipeline. Compares
// the ID-stage source registers against the EX and MEM destinations, decides
// whether to stall, bubble or flush IF/ID, sequences the two-cycle
// branch-after-load stall, services the debug halt handshake and keeps
// saturating stall/flush performance counters.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_rs, id_rt                ID source registers
//   id_uses_rs, id_uses_rt      ID instruction reads that operand
//   id_is_branch                ID holds a beq/bne (resolved in ID)
//   id_branch_taken, id_jump    redirect resolved in ID this cycle
//   ex_reg_write, ex_mem_read   EX writes a register / is a load
//   ex_rd                       EX destination register
//   mem_mem_read, mem_rd        MEM is a load / MEM destination register
//   halt_req                    debug halt request (level)
//   pc_write, ifid_write        PC / IF-ID enables
//   ifid_flush                  clear IF/ID to a nop
//   ctrl_sel                    1 = pass ID control, 0 = bubble
//   halt_ack                    registered, pipeline frozen for debug
//   stall_cycles, flush_count   saturating performance counters
// -----------------------------------------------------------------------------
module hazard_detect_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_branch_taken,
    input  logic             id_jump,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             mem_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             ctrl_sel,
    output logic             halt_ack,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0] RUN   = 2'b00;
    localparam logic [1:0] STALL = 2'b01;
    localparam logic [1:0] HALT  = 2'b10;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Register 0 is hard-wired zero, so it can never be a real producer.
    function automatic logic reg_match(input logic [4:0] rd,
                                       input logic [4:0] rs, input logic use_rs,
                                       input logic [4:0] rt, input logic use_rt);
        reg_match = (rd != 5'd0) &&
                    (((rd == rs) && use_rs) || ((rd == rt) && use_rt));
    endfunction

    logic [1:0]       state_r, state_nxt_s;
    logic [1:0]       rem_r, rem_nxt_s;
    logic             halt_ack_r;
    logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

    logic ex_match_s, mem_match_s;
    logic hz_len1_s, hz_len2_s, hz_any_s;
    logic stall_s, flush_s;
    logic pc_write_s, ifid_write_s, ctrl_sel_s;

    // Hazard classification against EX and MEM destinations.
    always_comb begin
        ex_match_s  = reg_match(ex_rd,  id_rs, id_uses_rs, id_rt, id_uses_rt);
        mem_match_s = reg_match(mem_rd, id_rs, id_uses_rs, id_rt, id_uses_rt);
        // L1 (load-use), B1 (branch on ALU result), B1M (branch on MEM load)
        hz_len1_s = (ex_mem_read & ex_match_s) |
                    (id_is_branch & ex_reg_write & ex_match_s & ~ex_mem_read) |
                    (id_is_branch & mem_mem_read & mem_match_s);
        // B2 (branch directly behind a load) needs the load to reach WB
        hz_len2_s = id_is_branch & ex_mem_read & ex_match_s;
        hz_any_s  = hz_len1_s | hz_len2_s;
    end

    // Next-state, remaining-stall and pipeline control decode.
    always_comb begin
        state_nxt_s  = state_r;
        rem_nxt_s    = rem_r;
        stall_s      = 1'b0;
        flush_s      = 1'b0;
        pc_write_s   = 1'b0;
        ifid_write_s = 1'b0;
        ctrl_sel_s   = 1'b0;
        case (state_r)
            RUN: begin
                if (hz_any_s) begin
                    // Stall beats flush: branch operands are not valid yet.
                    stall_s = 1'b1;
                    if (hz_len2_s) begin
                        rem_nxt_s   = 2'd1;
                        state_nxt_s = STALL;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    pc_write_s   = 1'b1;
                    ifid_write_s = 1'b1;
                    ctrl_sel_s   = 1'b1;
                    flush_s      = id_branch_taken | id_jump;
                    if (halt_req) begin
                        state_nxt_s = HALT;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
            end
            STALL: begin
                stall_s   = 1'b1;
                rem_nxt_s = rem_r - 2'd1;
                if (rem_r <= 2'd1) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = STALL;
                end
            end
            HALT: begin
                if (halt_req) begin
                    state_nxt_s = HALT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = RUN;
                rem_nxt_s   = 2'd0;
            end
        endcase
    end

    // Outputs are forced low while reset is asserted.
    always_comb begin
        pc_write   = rst_n & pc_write_s;
        ifid_write = rst_n & ifid_write_s;
        ctrl_sel   = rst_n & ctrl_sel_s;
        ifid_flush = rst_n & flush_s;
    end

    // Sequencer state, halt acknowledge and saturating counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= RUN;
            rem_r       <= 2'd0;
            halt_ack_r  <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            rem_r      <= rem_nxt_s;
            halt_ack_r <= (state_nxt_s == HALT);
            if (stall_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign halt_ack     = halt_ack_r;
    assign stall_cycles = stall_cnt_r;
    assign flush_count  = flush_cnt_r;

endmodule

// File: tb/tb_hazard_detect_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_detect_unit
//
// Directed self-checking bench for hazard_detect_unit. Inputs change 1 ns after
// the rising edge; combinational outputs are checked 1 ns later, well before
// the next edge, and registered outputs are checked after each edge.
// -----------------------------------------------------------------------------
module tb_hazard_detect_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
    logic        id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken, id_jump;
    logic        ex_reg_write, ex_mem_read, mem_mem_read, halt_req;
    logic        pc_write, ifid_write, ifid_flush, ctrl_sel, halt_ack;
    logic [15:0] stall_cycles, flush_count;

    int n_assert = 0;
    int n_fail   = 0;

    hazard_detect_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
        .id_jump(id_jump),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
        .halt_req(halt_req),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .ctrl_sel(ctrl_sel), .halt_ack(halt_ack),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Checks pc_write, ifid_write and ctrl_sel together against one value.
    task automatic chk_pipe(input string tag, input logic exp);
        chk({tag, "_pc"},   {31'd0, pc_write},   {31'd0, exp});
        chk({tag, "_ifid"}, {31'd0, ifid_write}, {31'd0, exp});
        chk({tag, "_ctrl"}, {31'd0, ctrl_sel},   {31'd0, exp});
    endtask

    task automatic clear_in();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0; mem_rd = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_branch = 1'b0;
        id_branch_taken = 1'b0; id_jump = 1'b0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; mem_mem_read = 1'b0;
        halt_req = 1'b0;
    endtask

    // Advance one clock; return 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_in();
        rst_n = 1'b0;
        step();
        #1;
        // Reset values
        chk_pipe("rst", 1'b0);
        chk("rst_flush", {31'd0, ifid_flush}, 32'd0);
        chk("rst_hack",  {31'd0, halt_ack},   32'd0);
        chk("rst_stall", {16'd0, stall_cycles}, 32'd0);
        chk("rst_fcnt",  {16'd0, flush_count},  32'd0);
        rst_n = 1'b1;
        #1;
        chk_pipe("run_idle", 1'b1);

        // Load-use (L1): single stall cycle
        step();
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        #1;
        chk_pipe("l1_stall", 1'b0);
        step();
        clear_in();
        #1;
        chk_pipe("l1_after", 1'b1);
        chk("l1_cnt", {16'd0, stall_cycles}, 32'd1);

        // Branch after load (B2): RUN stall then STALL
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
        id_is_branch = 1'b1;
        #1;
        chk_pipe("b2_s1", 1'b0);
        step();
        clear_in();
        #1;
        chk_pipe("b2_s2", 1'b0);
        step();
        #1;
        chk_pipe("b2_after", 1'b1);
        chk("b2_cnt", {16'd0, stall_cycles}, 32'd3);

        // Branch on EX ALU result (B1)
        id_is_branch = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd4;
        id_rs = 5'd4; id_uses_rs = 1'b1;
        #1;
        chk_pipe("b1_stall", 1'b0);
        step();
        clear_in();
        // Branch on MEM load (B1M)
        id_is_branch = 1'b1; mem_mem_read = 1'b1; mem_rd = 5'd7;
        id_rt = 5'd7; id_uses_rt = 1'b1;
        #1;
        chk_pipe("b1m_stall", 1'b0);
        step();
        // Same MEM load match without a branch is not a hazard
        id_is_branch = 1'b0;
        #1;
        chk_pipe("memld_nobr", 1'b1);
        step();
        clear_in();
        chk("b1_b1m_cnt", {16'd0, stall_cycles}, 32'd5);

        // $zero never hazards; unused operand never hazards
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        #1;
        chk_pipe("zero_reg", 1'b1);
        step();
        clear_in();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b0;
        #1;
        chk_pipe("unused_rt", 1'b1);
        step();
        clear_in();
        chk("zero_cnt", {16'd0, stall_cycles}, 32'd5);

        // Taken branch flushes IF/ID
        id_branch_taken = 1'b1;
        #1;
        chk("tk_flush", {31'd0, ifid_flush}, 32'd1);
        chk("tk_pc",    {31'd0, pc_write},   32'd1);
        step();
        chk("tk_fcnt", {16'd0, flush_count}, 32'd1);
        // Taken branch with L1 hazard: stall wins
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
        #1;
        chk("tkl1_flush", {31'd0, ifid_flush}, 32'd0);
        chk_pipe("tkl1", 1'b0);
        step();
        clear_in();
        chk("tkl1_fcnt", {16'd0, flush_count}, 32'd1);
        chk("tkl1_scnt", {16'd0, stall_cycles}, 32'd6);

        // Halt requested while a B2 stall is in progress
        id_is_branch = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd10;
        id_rs = 5'd10; id_uses_rs = 1'b1; halt_req = 1'b1;
        #1;
        chk_pipe("hs_run", 1'b0);
        step();
        clear_in();
        halt_req = 1'b1;
        #1;
        chk_pipe("hs_stall", 1'b0);
        chk("hs_stall_ack", {31'd0, halt_ack}, 32'd0);
        step();
        #1;
        chk_pipe("hs_runonce", 1'b1);
        chk("hs_run_ack", {31'd0, halt_ack}, 32'd0);
        step();
        id_branch_taken = 1'b1;
        #1;
        chk("h_ack", {31'd0, halt_ack}, 32'd1);
        chk_pipe("h_frozen", 1'b0);
        chk("h_flush", {31'd0, ifid_flush}, 32'd0);
        step();
        chk("h_ack2", {31'd0, halt_ack}, 32'd1);
        chk("h_scnt", {16'd0, stall_cycles}, 32'd8);
        chk("h_fcnt", {16'd0, flush_count}, 32'd1);
        halt_req = 1'b0; id_branch_taken = 1'b0;
        #1;
        chk_pipe("h_drop", 1'b0);
        step();
        #1;
        chk("h_exit_ack", {31'd0, halt_ack}, 32'd0);
        chk_pipe("h_exit", 1'b1);
        chk("h_exit_scnt", {16'd0, stall_cycles}, 32'd8);

        // Reset asserted mid-STALL
        id_is_branch = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd12;
        id_rt = 5'd12; id_uses_rt = 1'b1;
        step();
        clear_in();
        #1;
        chk_pipe("rs_install", 1'b0);
        rst_n = 1'b0;
        #1;
        chk_pipe("rs_rst", 1'b0);
        chk("rs_scnt", {16'd0, stall_cycles}, 32'd0);
        chk("rs_fcnt", {16'd0, flush_count},  32'd0);
        chk("rs_ack",  {31'd0, halt_ack},     32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk_pipe("rs_run", 1'b1);

        // Saturation: hold an L1 hazard for 65535 cycles, then a few more
        step();
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        repeat (65535) step();
        chk("sat_reach", {16'd0, stall_cycles}, 32'h0000FFFF);
        repeat (3) step();
        chk("sat_hold", {16'd0, stall_cycles}, 32'h0000FFFF);
        clear_in();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_detect_unit.md
# hazard_detect_unit

Hazard detection and stall sequencer for the 5-stage MIPS pipeline; sits upstream of the control-bubble mux and drives its select. Each cycle it compares the ID-stage source registers against the destinations in EX and MEM and decides whether to stall, insert a bubble or flush IF/ID. It also sequences multi-cycle stalls, services a debug halt handshake and keeps saturating stall/flush counters.

## Interface
- CNT_W, 16, width of the performance counters
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  the ID instruction reads that operand
- id_is_branch  in  1  ID holds a beq/bne, resolved in ID
- id_branch_taken, id_jump  in  1 each  redirect resolved in ID this cycle
- ex_reg_write, ex_mem_read  in  1 each  EX instruction writes a register / is a load
- ex_rd  in  5  EX destination register
- mem_mem_read  in  1  MEM instruction is a load
- mem_rd  in  5  MEM destination register
- halt_req  in  1  debug halt request, level
- pc_write  out  1  PC may update
- ifid_write  out  1  IF/ID may load
- ifid_flush  out  1  clear IF/ID to a nop
- ctrl_sel  out  1  1 = pass ID control signals, 0 = bubble (select of the control-bubble mux)
- halt_ack  out  1  registered; pipeline is frozen for debug
- stall_cycles  out  CNT_W  saturating count of hazard-stall cycles
- flush_count  out  CNT_W  saturating count of flush cycles

## Operation
- A match exists when rd != 0, rd equals id_rs with id_uses_rs, or rd equals id_rt with id_uses_rt.
- Hazard classes, evaluated in RUN only:
  - L1: ex_mem_read and EX match. Stall length 1.
  - B1: id_is_branch, ex_reg_write and EX match, not ex_mem_read. Stall length 1.
  - B2: id_is_branch, ex_mem_read and EX match. Stall length 2.
  - B1M: id_is_branch, mem_mem_read and MEM match. Stall length 1.
  - When several classes hit, the largest length wins.
- Stall cycle outputs: pc_write=0, ifid_write=0, ctrl_sel=0, ifid_flush=0.
- States:
  - RUN
    - Hazard of length 1: stall this cycle, stay in RUN.
    - Hazard of length 2: stall this cycle, load rem=1, go to STALL.
    - No hazard, halt_req=1: go to HALT (this cycle itself runs normally).
    - No hazard, halt_req=0: pc_write=1, ifid_write=1, ctrl_sel=1.
    - With no hazard, ifid_flush = id_branch_taken | id_jump.
  - STALL: stall outputs regardless of inputs; decrement rem; go to RUN when rem reaches 0. halt_req is ignored until back in RUN.
  - HALT: pc_write=0, ifid_write=0, ctrl_sel=0, ifid_flush=0, halt_ack=1. Leave to RUN on the first edge with halt_req=0.
- Priority: stall over flush, because branch operands are not yet valid. Halt entry only from RUN with no hazard.
- Counters:
  - stall_cycles increments on every cycle with stall outputs in RUN or STALL, not HALT.
  - flush_count increments on every cycle with ifid_flush=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Hazard detection and all outputs except halt_ack, stall_cycles and flush_count are combinational from the current inputs and state; no added latency.
- state, rem, halt_ack and the counters update on the rising clk edge.
- halt_ack rises on the edge entering HALT and falls on the edge leaving it.
- While rst_n=0, asynchronously:
  - state=RUN, rem=0, halt_ack=0, counters=0.
  - pc_write=0, ifid_write=0, ctrl_sel=0, ifid_flush=0.
- Reset asserted mid-STALL or mid-HALT aborts immediately to these values. After release, the first cycle is evaluated in RUN.
- Register 0 never produces a hazard, whatever the write or load flags say.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_uses_rs=1 -> one cycle with pc_write=0, ifid_write=0, ctrl_sel=0. Next cycle, with EX cleared, all three are 1. stall_cycles=1.
- Branch after load: id_is_branch=1, ex_mem_read=1, ex_rd=9, id_rt=9 -> exactly 2 stall cycles (RUN then STALL). Back to RUN, stall_cycles=2.
- $zero and unused operands:
  - ex_mem_read=1, ex_rd=0, id_rs=0 -> no stall.
  - ex_rd=5, id_rt=5, id_uses_rt=0 -> no stall.
- Taken branch: id_branch_taken=1 with no hazard -> ifid_flush=1, pc_write=1 for one cycle, flush_count=1. Same with a simultaneous L1 hazard -> ifid_flush=0, stall wins.
- Halt handshake:
  - halt_req=1 during STALL -> HALT entered only after the stall completes.
  - halt_ack=1 one edge later, outputs frozen.
  - Dropping halt_req -> RUN next edge.
  - stall_cycles does not count HALT cycles.
- Saturation and reset: preload by forcing 0xFFFF stall cycles -> stall_cycles holds at 0xFFFF. rst_n pulsed low mid-STALL -> all outputs and counters 0 immediately, RUN after release.
